mult_seq_arb: RTL and testbench

MULT_SEQ_ARB -- requirements
Module: mult_seq_arb

---
 rtl/mult_seq_pkg.sv | 13 +
 rtl/mult_seq_step.sv | 19 +
 rtl/mult_seq_arb.sv | 155 +++++++++++++++
 tb/tb_mult_seq_arb.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier arbiter.
// Holds the FSM state encoding and the default operand width.
package mult_seq_pkg;

  localparam int unsigned MULT_SEQ_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_seq_step.sv
// Single shared WIDTH-bit adder with carry-out used by each multiply step.
// Ports:
//   a_i, b_i  - addends
//   sum_o     - WIDTH-bit sum
//   carry_o   - carry out of the top bit
module mult_seq_step
  import mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_SEQ_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  assign {carry_o, sum_o} = (WIDTH+1)'(a_i) + (WIDTH+1)'(b_i);

endmodule

// File: rtl/mult_seq_arb.sv
// Two-requester round-robin front end to one iterative shift-and-add
// multiplier. A granted request is latched, multiplied over WIDTH RUN
// cycles, then presented in DONE until the consumer takes it.
// Optional feature: define MULT_SEQ_EARLY_EN to skip RUN when either
// operand is zero (result 0, presented one cycle after transfer).
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   req_valid/req_ready   - per-requester handshake (bit i = requester i)
//   req_a0/b0, req_a1/b1  - operands of requester 0 and 1
//   rsp_valid/rsp_ready   - product handshake
//   rsp_id, rsp_p         - owner and value of the product
//   busy                  - FSM not in IDLE
module mult_seq_arb
  import mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_SEQ_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [WIDTH-1:0]   req_a0,
  input  logic [WIDTH-1:0]   req_b0,
  input  logic [WIDTH-1:0]   req_a1,
  input  logic [WIDTH-1:0]   req_b1,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_p,
  output logic               busy
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic               prio_q, prio_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               id_q, id_d;
  logic [PW-1:0]      rsp_p_q, rsp_p_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;

  logic               gnt;
  logic               xfer;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [WIDTH-1:0]   step_addend, step_sum;
  logic               step_carry;
  logic [PW-1:0]      prod_shift;

  // Arbitration: favoured requester wins a tie, a lone requester always wins.
  // Ready is only offered in IDLE and never while reset is asserted.
  always_comb begin
    gnt       = (req_valid == 2'b11) ? prio_q : req_valid[1];
    req_ready = 2'b00;
    if (rst_n && (state_q == ST_IDLE) && (req_valid != 2'b00)) begin
      req_ready = gnt ? 2'b10 : 2'b01;
    end
    xfer = |(req_valid & req_ready);
    op_a = gnt ? req_a1 : req_a0;
    op_b = gnt ? req_b1 : req_b0;
  end

  // Multiplier lives in the low half of prod_q; its LSB gates the add.
  assign step_addend = prod_q[0] ? a_q : '0;

  mult_seq_step #(.WIDTH(WIDTH)) u_step (
    .a_i     (prod_q[PW-1:WIDTH]),
    .b_i     (step_addend),
    .sum_o   (step_sum),
    .carry_o (step_carry)
  );

  assign prod_shift = {step_carry, step_sum, prod_q[WIDTH-1:1]};

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    a_d     = a_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    rsp_p_d = rsp_p_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          a_d     = op_a;
          prod_d  = {WIDTH'(0), op_b};
          cnt_d   = '0;
          id_d    = gnt;
          prio_d  = ~gnt;
          state_d = ST_RUN;
`ifdef MULT_SEQ_EARLY_EN
          if ((op_a == '0) || (op_b == '0)) begin
            rsp_p_d = '0;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_RUN: begin
        prod_d = prod_shift;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          rsp_p_d = prod_shift;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rsp_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      a_q         <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      rsp_p_q     <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      a_q         <= a_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      rsp_p_q     <= rsp_p_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_p     = rsp_p_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mult_seq_arb.sv
// Directed self-checking bench for mult_seq_arb: reset values, single and
// contended requests, response back-pressure, reset abort, zero operands
// and a full operand sweep on both requesters.
module tb_mult_seq_arb;

  localparam int unsigned WIDTH = 4;

  logic               clk;
  logic               rst_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [WIDTH-1:0]   req_a0, req_b0, req_a1, req_b1;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_p;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  mult_seq_arb #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle after transfer; returns cycles until rsp_valid.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  // One lone request from requester id, consumed immediately.
  task automatic do_req(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int lat;
    int exp_lat;
    logic [2*WIDTH-1:0] exp_p;
    exp_p   = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    exp_lat = WIDTH + 1;
`ifdef MULT_SEQ_EARLY_EN
    if (a == '0 || b == '0) exp_lat = 1;
`endif
    rsp_ready = 1'b1;
    if (id == 0) begin
      req_a0 = a; req_b0 = b; req_valid = 2'b01;
    end else begin
      req_a1 = b; req_b1 = a; req_valid = 2'b10;
      req_a1 = a; req_b1 = b;
    end
    #1;
    chk("grant", 32'(req_ready), (id == 0) ? 32'd1 : 32'd2);
    tick();
    req_valid = 2'b00;
    req_a0 = ~a; req_b0 = ~b; req_a1 = ~b; req_b1 = ~a;
    wait_rsp(lat);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("product", 32'(rsp_p), 32'(exp_p));
    chk("rsp_id", 32'(rsp_id), 32'(id));
    tick();
    chk("back_idle", 32'(busy), 32'd0);
  endtask

  int  lat;
  logic seen;

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a0 = 4'd1; req_b0 = 4'd1; req_a1 = 4'd1; req_b1 = 4'd1;
    rsp_ready = 1'b1;

    // Reset values, with both requesters asserting.
    tick(); tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_p", 32'(rsp_p), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick();

    // Requester 0: 3*5.
    do_req(0, 4'd3, 4'd5);

    // Contention from a fresh reset: grants 0,1,0.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req_a0 = 4'd2; req_b0 = 4'd7; req_a1 = 4'd15; req_b1 = 4'd15;
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    chk("rr_grant0", 32'(req_ready), 32'd1);
    tick();
    wait_rsp(lat);
    chk("rr_lat0", 32'(lat), 32'd5);
    chk("rr_p0", 32'(rsp_p), 32'd14);
    chk("rr_id0", 32'(rsp_id), 32'd0);
    chk("rr_done_ready", 32'(req_ready), 32'd0);
    tick();
    chk("rr_grant1", 32'(req_ready), 32'd2);
    tick();
    wait_rsp(lat);
    chk("rr_p1", 32'(rsp_p), 32'd225);
    chk("rr_id1", 32'(rsp_id), 32'd1);
    tick();
    chk("rr_grant2", 32'(req_ready), 32'd1);
    tick();
    wait_rsp(lat);
    chk("rr_p2", 32'(rsp_p), 32'd14);
    chk("rr_id2", 32'(rsp_id), 32'd0);
    req_valid = 2'b00;
    tick();
    chk("rr_idle", 32'(busy), 32'd0);

    // Back-pressure: DONE held 10 cycles while others request.
    req_a1 = 4'd6; req_b1 = 4'd7; req_valid = 2'b10; rsp_ready = 1'b0;
    tick();
    req_valid = 2'b00;
    wait_rsp(lat);
    req_valid = 2'b11; req_a0 = 4'd1; req_b0 = 4'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_p", 32'(rsp_p), 32'd42);
      chk("hold_id", 32'(rsp_id), 32'd1);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    chk("hold_release", 32'(rsp_valid), 32'd0);
    tick();
    chk("hold_no_accept", 32'(busy), 32'd0);

    // Reset during RUN step 2 of 9*9.
    req_a0 = 4'd9; req_b0 = 4'd9; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_p", 32'(rsp_p), 32'd0);
    seen = rsp_valid;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | rsp_valid;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);

    // Zero operand.
    do_req(0, 4'd0, 4'd11);
    do_req(1, 4'd11, 4'd0);

    // All operand pairs on both requesters.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_req(0, WIDTH'(a), WIDTH'(b));
        do_req(1, WIDTH'(a), WIDTH'(b));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
